// File: rtl/mult_pkg.sv
// Shared types and helpers for the shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    // Widest operand ext() can handle; WIDTH must stay below this.
    localparam int MAX_W = 64;

    // Extends the low `width` bits of s to width+1 bits and beyond.
    // The sign bit is copied upward when sgn is set; otherwise zeros fill the top.
    function automatic logic [MAX_W:0] ext(
        input logic [MAX_W-1:0] s,
        input int               width,
        input logic             sgn
    );
        logic [MAX_W:0]   low_mask;
        logic [MAX_W-1:0] msb_down;
        low_mask = ({{MAX_W{1'b0}}, 1'b1} << width) - {{MAX_W{1'b0}}, 1'b1};
        msb_down = s >> (width - 1);
        ext      = {1'b0, s} & low_mask;
        if (sgn && msb_down[0]) begin
            ext = ext | ~low_mask;
        end
    endfunction

endpackage

// File: rtl/addsub_ext.sv
// Combinational W-bit adder/subtractor forming the partial-product sum T.
module addsub_ext #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] y
);

    assign y = sub ? (a - b) : (a + b);

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier: X:A:B <= S * B, one multiplier bit per cycle,
// with unsigned or two's-complement operands and a Busy/Done handshake.
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Run,
    input  logic             LoadB,
    input  logic             ClearA,
    input  logic             Signed,
    input  logic [WIDTH-1:0] Din,
    output logic             Xval,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             Busy,
    output logic             Done
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic             x_q, x_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sgn_q, sgn_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             last_bit;
    logic [MAX_W-1:0] s_wide;
    logic [MAX_W:0]   s_ext_wide;
    logic             ext_unused;
    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   sum;

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        s_wide            = '0;
        s_wide[WIDTH-1:0] = s_q;
    end

    assign s_ext_wide = ext(s_wide, WIDTH, sgn_q);
    assign ext_unused = ^s_ext_wide[MAX_W:WIDTH+1];
    assign addend     = b_q[0] ? s_ext_wide[WIDTH:0] : '0;

    // The final bit of a two's-complement multiplier carries negative weight,
    // so that step subtracts S instead of adding it.
    addsub_ext #(
        .W (WIDTH + 1)
    ) u_addsub (
        .a   ({x_q, a_q}),
        .b   (addend),
        .sub (last_bit & sgn_q),
        .y   (sum)
    );

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        x_d     = x_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE, HOLD: begin
                if (LoadB) begin
                    b_d = Din;
                end
                if (ClearA) begin
                    x_d = 1'b0;
                    a_d = '0;
                end
                if (state_q == HOLD) begin
                    if (!Run) begin
                        state_d = IDLE;
                    end
                end else if (!LoadB && !ClearA && Run) begin
                    s_d     = Din;
                    sgn_d   = Signed;
                    x_d     = 1'b0;
                    a_d     = '0;
                    cnt_d   = '0;
                    state_d = COMPUTE;
                end
            end

            COMPUTE: begin
                // Unsigned carries land in A's MSB; only signed mode keeps a sign in X.
                x_d   = sgn_q & sum[WIDTH];
                a_d   = sum[WIDTH:1];
                b_d   = {sum[0], b_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    state_d = HOLD;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == COMPUTE);
    end

    // NOTE: reset is sampled on the clock edge here, and state updates use <= only.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            x_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Xval = x_q;
    assign Aval = a_q;
    assign Bval = b_q;
    assign Busy = busy_q;
    assign Done = done_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench: directed corner cases plus randomized traffic against a
// product-level reference model; a second instance covers WIDTH=16.
module tb_shift_add_multiplier;

    localparam int W   = 8;
    localparam int W16 = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, run, loadb, cleara, sgn;
    logic [W-1:0] din;
    logic         x, busy, done;
    logic [W-1:0] a, b;

    logic           run_w, loadb_w, cleara_w, sgn_w;
    logic [W16-1:0] din_w;
    logic           x_w, busy_w, done_w;
    logic [W16-1:0] a_w, b_w;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;

    shift_add_multiplier #(.WIDTH(W)) dut (
        .Clk(clk), .Reset_n(rst_n), .Run(run), .LoadB(loadb), .ClearA(cleara),
        .Signed(sgn), .Din(din), .Xval(x), .Aval(a), .Bval(b), .Busy(busy), .Done(done)
    );

    shift_add_multiplier #(.WIDTH(W16)) dut16 (
        .Clk(clk), .Reset_n(rst_n), .Run(run_w), .LoadB(loadb_w), .ClearA(cleara_w),
        .Signed(sgn_w), .Din(din_w), .Xval(x_w), .Aval(a_w), .Bval(b_w), .Busy(busy_w),
        .Done(done_w)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
    endtask

    // Reference model: works on whole products, not on individual shift steps.
    typedef enum {M_IDLE, M_BUSY, M_HOLD} mphase_t;
    mphase_t       m_phase = M_IDLE;
    int            m_left  = 0;
    logic          m_x = 1'b0, m_done = 1'b0, m_sgn = 1'b0;
    logic [W-1:0]  m_a = '0, m_b = '0;
    logic [2*W-1:0] m_prod = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = M_IDLE; m_left = 0; m_x = 1'b0; m_a = '0; m_b = '0;
            m_done = 1'b0; m_sgn = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_phase == M_BUSY) begin
                m_left--;
                if (m_left == 0) begin
                    m_phase    = M_HOLD;
                    m_done     = 1'b1;
                    {m_a, m_b} = m_prod;
                    m_x        = m_sgn & m_prod[2*W-1];
                end
            end else begin
                if (loadb) m_b = din;
                if (cleara) begin m_x = 1'b0; m_a = '0; end
                if (m_phase == M_HOLD) begin
                    if (!run) m_phase = M_IDLE;
                end else if (!loadb && !cleara && run) begin
                    m_sgn  = sgn;
                    m_prod = sgn ? 16'($signed({{W{din[W-1]}}, din}) * $signed({{W{m_b[W-1]}}, m_b}))
                                 : 16'({{W{1'b0}}, din} * {{W{1'b0}}, m_b});
                    m_x     = 1'b0;
                    m_a     = '0;
                    m_left  = W;
                    m_phase = M_BUSY;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_busy", 32'(busy), 32'(m_phase == M_BUSY));
            check("model_done", 32'(done), 32'(m_done));
            if (m_phase != M_BUSY) begin
                check("model_x", 32'(x), 32'(m_x));
                check("model_a", 32'(a), 32'(m_a));
                check("model_b", 32'(b), 32'(m_b));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load_b(input logic [W-1:0] v);
        loadb = 1'b1; din = v; tick(); loadb = 1'b0;
    endtask

    // Starts a multiply and returns at the negedge where Done is visible.
    task automatic mult(input logic [W-1:0] s, input logic sg, input bit hold_run, output int lat);
        run = 1'b1; din = s; sgn = sg; lat = 0;
        do begin tick(); lat++; end while (!done && lat < 40);
        if (!hold_run) run = 1'b0;
    endtask

    task automatic mult16(input logic [W16-1:0] s, input logic [W16-1:0] bv, output int lat);
        loadb_w = 1'b1; din_w = bv; tick(); loadb_w = 1'b0;
        run_w = 1'b1; din_w = s; sgn_w = 1'b0; lat = 0;
        do begin tick(); lat++; end while (!done_w && lat < 60);
        run_w = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic ex, input logic [W-1:0] ea,
                                 input logic [W-1:0] eb);
        check({tag, "_x"}, 32'(x), 32'(ex));
        check({tag, "_a"}, 32'(a), 32'(ea));
        check({tag, "_b"}, 32'(b), 32'(eb));
    endtask

    initial begin
        int lat;
        int extra;
        logic [W-1:0] pa [8];
        logic [W-1:0] pb [8];
        logic [W16-1:0] rs, rb;
        logic [31:0] p16;

        rst_n = 1'b0; run = 1'b0; loadb = 1'b0; cleara = 1'b0; sgn = 1'b0; din = '0;
        run_w = 1'b0; loadb_w = 1'b0; cleara_w = 1'b0; sgn_w = 1'b0; din_w = '0;
        tick();
        cmp_en = 1'b1;
        tick();
        rst_n = 1'b1;
        expect_result("reset", 1'b0, 8'h00, 8'h00);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);

        // Reset mid-COMPUTE discards the partial result.
        load_b(8'hC5);
        run = 1'b1; din = 8'h07; sgn = 1'b0;
        repeat (4) tick();
        check("midrun_busy", 32'(busy), 32'h1);
        run = 1'b0; rst_n = 1'b0;
        repeat (3) tick();
        expect_result("midrun_reset", 1'b0, 8'h00, 8'h00);
        check("midrun_reset_busy", 32'(busy), 32'h0);
        check("midrun_reset_done", 32'(done), 32'h0);
        rst_n = 1'b1;
        tick();
        check("post_reset_idle", 32'(busy), 32'h0);

        load_b(8'hC5);
        mult(8'h07, 1'b0, 1'b0, lat);
        check("u_c5x07_latency", 32'(lat), 32'd9);
        expect_result("u_c5x07", 1'b0, 8'h05, 8'h63);
        tick();
        load_b(8'hC5);
        mult(8'h07, 1'b1, 1'b0, lat);
        check("s_c5x07_latency", 32'(lat), 32'd9);
        expect_result("s_c5x07", 1'b1, 8'hFE, 8'h63);
        tick();

        load_b(8'h80); mult(8'h80, 1'b1, 1'b0, lat); expect_result("s_80x80", 1'b0, 8'h40, 8'h00); tick();
        load_b(8'hFF); mult(8'hFF, 1'b1, 1'b0, lat); expect_result("s_ffxff", 1'b0, 8'h00, 8'h01); tick();
        load_b(8'hFF); mult(8'hFF, 1'b0, 1'b0, lat); expect_result("u_ffxff", 1'b0, 8'hFE, 8'h01); tick();

        // Run held high after Done: one pulse only, no restart; then chain on old B.
        load_b(8'hC5);
        mult(8'h07, 1'b1, 1'b1, lat);
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) extra++;
        end
        check("held_run_no_restart", 32'(extra), 32'h0);
        check("held_run_b_kept", 32'(b), 32'h63);
        run = 1'b0;
        tick();
        mult(8'h07, 1'b1, 1'b0, lat);
        expect_result("chain_07x63", 1'b0, 8'h02, 8'hB5);
        tick();

        // LoadB/ClearA during COMPUTE are ignored.
        load_b(8'h12);
        run = 1'b1; din = 8'h34; sgn = 1'b0;
        tick(); tick();
        loadb = 1'b1; cleara = 1'b1; din = 8'hAA;
        tick();
        loadb = 1'b0; cleara = 1'b0;
        lat = 3;
        while (!done && lat < 40) begin tick(); lat++; end
        check("busy_ignore_latency", 32'(lat), 32'd9);
        expect_result("busy_ignore", 1'b0, 8'h03, 8'hA8);
        cleara = 1'b1;
        tick();
        cleara = 1'b0;
        expect_result("hold_cleara", 1'b0, 8'h00, 8'hA8);
        run = 1'b0;
        tick();
        run = 1'b1; loadb = 1'b1; din = 8'h5A;
        tick();
        run = 1'b0; loadb = 1'b0;
        check("run_with_loadb_b", 32'(b), 32'h5A);
        check("run_with_loadb_nostart", 32'(busy), 32'h0);
        tick();
        check("run_with_loadb_idle", 32'(busy), 32'h0);

        // Operand corners in both modes; the model checks every cycle.
        pa = '{8'h7F, 8'h80, 8'h00, 8'h80, 8'h01, 8'hFF, 8'h7F, 8'h81};
        pb = '{8'h80, 8'h7F, 8'hFF, 8'h01, 8'hFF, 8'h01, 8'h7F, 8'h81};
        for (int i = 0; i < 8; i++) begin
            for (int m = 0; m < 2; m++) begin
                load_b(pb[i]);
                mult(pa[i], m[0], 1'b0, lat);
                check("corner_latency", 32'(lat), 32'd9);
                tick();
            end
        end

        // Randomized traffic: reload or chain, stray ClearA, held Run, occasional reset.
        for (int i = 0; i < 150; i++) begin
            bit hold;
            if ($urandom_range(0, 3) != 0) load_b(8'($urandom));
            if ($urandom_range(0, 7) == 0) begin cleara = 1'b1; tick(); cleara = 1'b0; end
            if ($urandom_range(0, 19) == 0) begin
                run = 1'b1; din = 8'($urandom); sgn = 1'($urandom);
                repeat ($urandom_range(1, 8)) tick();
                run = 1'b0; rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                tick();
            end else begin
                hold = ($urandom_range(0, 3) == 0);
                mult(8'($urandom), 1'($urandom), hold, lat);
                check("rand_latency", 32'(lat), 32'd9);
                if (hold) begin
                    repeat ($urandom_range(1, 4)) tick();
                    run = 1'b0;
                end
                tick();
            end
        end

        // WIDTH=16 instance, unsigned.
        mult16(16'h1234, 16'h0010, lat);
        check("w16_latency", 32'(lat), 32'd17);
        check("w16_a", 32'(a_w), 32'h0001);
        check("w16_b", 32'(b_w), 32'h2340);
        check("w16_x", 32'(x_w), 32'h0);
        tick();
        for (int i = 0; i < 20; i++) begin
            rs  = 16'($urandom);
            rb  = 16'($urandom);
            p16 = 32'(rs) * 32'(rb);
            mult16(rs, rb, lat);
            check("w16_rand_latency", 32'(lat), 32'd17);
            check("w16_rand_prod", {a_w, b_w}, p16);
            check("w16_rand_x", 32'(x_w), 32'h0);
            tick();
        end

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
